chip_bus_reader: RTL and testbench

CHIP_BUS_READER -- requirements
Module: chip_bus_reader

---
 rtl/chip_bus_reader.sv | 126 ++++++++++++
 tb/tb_chip_bus_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/chip_bus_reader.sv
// chip_bus_reader: accepts one read request at a time, issues a bus read, and holds
// the returned data (or a timeout error) until the consumer takes it.
// Optional macro CHIP_BUS_READER_PARITY_CHECK_EN: flag rsp_err when bus_par does not
// match the even parity of bus_data on an acked read.
module chip_bus_reader #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              bus_rd,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              bus_par,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_par,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StResp
    } state_t;

    // Last wait count before the timeout fires; READ then lasts exactly TIMEOUT cycles.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic              err_q, err_d;
    logic              par_bad;

`ifdef CHIP_BUS_READER_PARITY_CHECK_EN
    assign par_bad = bus_par != (^bus_data);
`else
    // Parity input is deliberately unused in this build.
    logic unused_bus_par;
    assign unused_bus_par = bus_par;
    assign par_bad = 1'b0;
`endif

    // Next-state, wait counter and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        par_d   = par_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StRead;
                    cnt_d   = 8'd0;
                    addr_d  = req_addr;
                end
            end
            StRead: begin
                // An ack on the timeout edge still wins.
                if (bus_ack) begin
                    state_d = StResp;
                    data_d  = bus_data;
                    par_d   = ^bus_data;
                    err_d   = par_bad;
                end else if (cnt_q == CntLast) begin
                    state_d = StResp;
                    data_d  = '0;
                    par_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            par_q   <= par_d;
            err_q   <= err_d;
        end
    end

    // Handshake and strobe outputs decode directly from state.
    always_comb begin
        req_ready = (state_q == StIdle);
        bus_rd    = (state_q == StRead);
        rsp_valid = (state_q == StResp);
        bus_addr  = addr_q;
        rsp_data  = data_q;
        rsp_par   = par_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_chip_bus_reader.sv
// Randomized self-checking bench for chip_bus_reader; expectations come from a
// transaction-level model (cycle counts, captured data, parity and error rules).
module tb_chip_bus_reader;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned TIMEOUT = 15;
`ifdef CHIP_BUS_READER_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              bus_rd;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_data;
    logic              bus_par;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_par;
    logic              rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    chip_bus_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .bus_rd   (bus_rd),
        .bus_addr (bus_addr),
        .bus_ack  (bus_ack),
        .bus_data (bus_data),
        .bus_par  (bus_par),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_par  (rsp_par),
        .rsp_err  (rsp_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] rand64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    // One full transaction starting at a negedge in IDLE. ack_at is the READ cycle
    // (1-based) carrying bus_ack; outside 1..TIMEOUT means no ack (timeout).
    task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic par, input int ack_at, input int hold);
        int          n;
        bit          timed_out;
        logic [63:0] exp_data;
        logic        exp_par;
        logic        exp_err;
        timed_out = (ack_at < 1) || (ack_at > int'(TIMEOUT));
        exp_data  = timed_out ? 64'd0 : data;
        exp_par   = timed_out ? 1'b0 : ^data;
        exp_err   = timed_out ? 1'b1 : (PAR_EN && (par != ^data));

        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        bus_ack   = 1'($urandom_range(0, 1));  // ack while idle must be ignored
        bus_data  = rand64();
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = 32'($urandom);
        bus_ack   = 1'b0;
        check("bus_addr", 64'(bus_addr), 64'(addr));
        check("req_ready_busy", 64'(req_ready), 64'd0);

        n = 0;
        while (bus_rd === 1'b1 && n < int'(TIMEOUT) + 5) begin
            n++;
            if (n == ack_at) begin
                bus_ack  = 1'b1;
                bus_data = data;
                bus_par  = par;
            end else begin
                bus_ack = 1'b0;
            end
            @(negedge clock);
        end
        bus_ack = 1'b0;
        check("bus_rd_cycles", 64'(n), timed_out ? 64'(TIMEOUT) : 64'(ack_at));
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_par", 64'(rsp_par), 64'(exp_par));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 32'($urandom);
            bus_ack   = 1'($urandom_range(0, 1));
            bus_data  = rand64();
            bus_par   = 1'($urandom_range(0, 1));
            @(negedge clock);
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_data", rsp_data, exp_data);
            check("hold_flags", {62'd0, rsp_par, rsp_err}, {62'd0, exp_par, exp_err});
            check("hold_ready", {62'd0, req_ready, bus_rd}, 64'd0);
        end

        // Handshake with a request already waiting: it must not be taken on this edge.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        bus_ack   = 1'b0;
        check("post_valid", 64'(rsp_valid), 64'd0);
        check("post_ready", 64'(req_ready), 64'd1);
        check("post_bus_rd", 64'(bus_rd), 64'd0);
    endtask

    // Reset during READ (cycle rd_cycle) or during RESP; nothing may survive it.
    task automatic reset_mid(input int rd_cycle, input bit in_resp);
        req_valid = 1'b1;
        req_addr  = 32'($urandom) | 32'h1;
        @(negedge clock);
        req_valid = 1'b0;
        if (in_resp) begin
            bus_ack  = 1'b1;
            bus_data = rand64() | 64'h1;
            @(negedge clock);
            bus_ack = 1'b0;
            check("rst_pre_resp", 64'(rsp_valid), 64'd1);
        end else begin
            repeat (rd_cycle - 1) @(negedge clock);
            check("rst_pre_read", 64'(bus_rd), 64'd1);
        end
        #1 reset = 1'b1;
        #1;
        check("rst_bus_rd", 64'(bus_rd), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_flags", {62'd0, rsp_par, rsp_err}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_ack  = 1'($urandom_range(0, 1));
            bus_data = rand64();
            @(negedge clock);
            check("rst_after_valid", 64'(rsp_valid), 64'd0);
            check("rst_after_idle", {62'd0, req_ready, bus_rd}, 64'd2);
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        bus_ack   = 1'b0;
        bus_data  = '0;
        bus_par   = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check("init_bus_rd", 64'(bus_rd), 64'd0);
        check("init_rsp_valid", 64'(rsp_valid), 64'd0);
        check("init_rsp_data", rsp_data, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_txn(32'h0000_1000, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 0);
        run_txn(32'($urandom), rand64(), 1'b0, 0, 1);
        run_txn(32'($urandom), 64'hFF, 1'b0, int'(TIMEOUT), 0);
        run_txn(32'($urandom), rand64(), 1'b1, 2, 10);
        run_txn(32'($urandom), 64'h1, 1'b0, 1, 0);
        run_txn(32'($urandom), 64'h3, 1'b1, 4, 2);
        reset_mid(2, 1'b0);
        run_txn(32'($urandom), rand64(), 1'b0, 5, 1);
        reset_mid(0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            run_txn(32'($urandom), rand64(), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, TIMEOUT + 3)), int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
